// File: rtl/calculator_core.sv
// Accumulator ALU behind the calculator display: debounced enter/clear buttons,
// single-cycle LOAD/ADD/SUB and 32-step iterative MUL/DIV/MOD.

module calculator_core_debounce #(
  parameter int DEB_CYCLES = 200000
) (
  input  logic clk_g,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync_1, sync_2, level, level_q;
  logic [CW-1:0] cnt;

  // The level flips only after DEB_CYCLES consecutive cycles that disagree with it.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_1  <= btn;
      sync_2  <= sync_1;
      level_q <= level;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign pulse = level & ~level_q;
endmodule

module calculator_core #(
  parameter int DEB_CYCLES = 200000,
  parameter int W          = 32
) (
  input  logic         clk_g,
  input  logic         rst_n,
  input  logic         btn_enter,
  input  logic         btn_clear,
  input  logic [2:0]   op_sel,
  input  logic [W-1:0] operand,
  output logic [W-1:0] cal_result,
  output logic         error,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MOD  = 3'd5;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, WRITE} state_t;

  state_t       state;
  logic         go, clr;
  logic [2:0]   op_q;
  logic [W-1:0] opnd_q, acc_q, hi, lo, res;
  logic         res_err;
  logic [4:0]   step;

  logic [W:0]   add_sum, mul_sum, div_r;
  logic [W-1:0] div_diff, fin_val;
  logic         div_ge, fin_err;

  calculator_core_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk_g(clk_g), .rst_n(rst_n), .btn(btn_enter), .pulse(go)
  );
  calculator_core_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk_g(clk_g), .rst_n(rst_n), .btn(btn_clear), .pulse(clr)
  );

  // hi:lo is the 64-bit product for MUL, and remainder:quotient for DIV/MOD.
  always_comb begin
    add_sum  = {1'b0, acc_q} + {1'b0, opnd_q};
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
    div_r    = {hi, lo[W-1]};
    div_ge   = div_r >= {1'b0, opnd_q};
    div_diff = div_r[W-1:0] - opnd_q;
    fin_val  = res;
    fin_err  = res_err;
    case (op_q)
      OP_MUL: begin
        fin_val = lo;
        fin_err = |hi;
      end
      OP_DIV:  fin_val = lo;
      OP_MOD:  fin_val = hi;
      default: ;
    endcase
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cal_result <= '0;
      error      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      op_q       <= OP_LOAD;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi         <= '0;
      lo         <= '0;
      res        <= '0;
      res_err    <= 1'b0;
      step       <= '0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state      <= IDLE;
        cal_result <= '0;
        error      <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // With the error flag up only LOAD is accepted.
            if (go && (!error || op_sel == OP_LOAD)) begin
              op_q   <= op_sel;
              opnd_q <= operand;
              acc_q  <= cal_result;
              busy   <= 1'b1;
              state  <= EXEC;
            end
          end
          EXEC: begin
            state <= WRITE;
            case (op_q)
              OP_LOAD: begin
                res     <= opnd_q;
                res_err <= 1'b0;
              end
              OP_ADD: begin
                res     <= add_sum[W-1:0];
                res_err <= add_sum[W];
              end
              OP_SUB: begin
                res     <= acc_q - opnd_q;
                res_err <= acc_q < opnd_q;
              end
              OP_MUL, OP_DIV, OP_MOD: begin
                if (op_q != OP_MUL && opnd_q == '0) begin
                  res_err <= 1'b1;
                end else begin
                  res_err <= 1'b0;
                  hi      <= '0;
                  lo      <= acc_q;
                  step    <= 5'd31;
                  state   <= ITER;
                end
              end
              default: res_err <= 1'b1;
            endcase
          end
          ITER: begin
            if (op_q == OP_MUL) begin
              hi <= mul_sum[W:1];
              lo <= {mul_sum[0], lo[W-1:1]};
            end else begin
              hi <= div_ge ? div_diff : div_r[W-1:0];
              lo <= {lo[W-2:0], div_ge};
            end
            step <= step - 5'd1;
            if (step == 5'd0) state <= WRITE;
          end
          WRITE: begin
            if (!fin_err) cal_result <= fin_val;
            error <= fin_err;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_calculator_core.sv
// Directed bench for calculator_core with a result scoreboard fed at stimulus time.

module tb_calculator_core;
  localparam int DEB = 4;

  logic        clk_g = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_enter = 1'b0;
  logic        btn_clear = 1'b0;
  logic [2:0]  op_sel = 3'd0;
  logic [31:0] operand = 32'd0;
  logic [31:0] cal_result;
  logic        error, busy, done;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int cyc = 0;
  int go_cyc = 0;
  int last_lat = 0;
  bit busy_seen = 1'b0;
  logic [32:0] exp_q[$];

  calculator_core #(.DEB_CYCLES(DEB)) dut (
    .clk_g(clk_g), .rst_n(rst_n), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .op_sel(op_sel), .operand(operand), .cal_result(cal_result), .error(error),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk_g = ~clk_g;
  always @(posedge clk_g) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every done pulse pops one expected {error, result}
  always @(negedge clk_g) begin
    logic [32:0] e;
    if (dut.go) go_cyc = cyc;
    if (busy) busy_seen = 1'b1;
    if (done) begin
      n_done++;
      last_lat = cyc - go_cyc;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_done observed=%0h expected=no_done", cal_result);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {31'd0, error, cal_result}, {31'd0, e});
      end
    end
  end

  // drivers
  task automatic do_op(input logic [2:0] op, input logic [31:0] val,
                       input logic [31:0] exp_res, input logic exp_err,
                       input int exp_lat, input string tag);
    int d0;
    d0 = n_done;
    exp_q.push_back({exp_err, exp_res});
    @(negedge clk_g);
    op_sel = op;
    operand = val;
    btn_enter = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (n_done != d0) break;
      @(posedge clk_g);
    end
    check({tag, "_done"}, 64'(n_done - d0), 64'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, 64'(last_lat), 64'(exp_lat));
    @(negedge clk_g);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk_g);
  endtask

  task automatic wait_iter(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (dbg_state == 2'd2) break;
      @(negedge clk_g);
    end
    check(tag, 64'(dbg_state), 64'd2);
  endtask

  initial begin
    int d0;
    logic [31:0] a, b;
    logic [63:0] p;

    // reset state
    repeat (3) @(negedge clk_g);
    check("rst_result", 64'(cal_result), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_g);

    // bouncing enter: 1-0-1 then held, one LOAD only
    d0 = n_done;
    exp_q.push_back({1'b0, 32'd7});
    op_sel = 3'd0;
    operand = 32'd7;
    btn_enter = 1'b1;
    @(negedge clk_g);
    btn_enter = 1'b0;
    @(negedge clk_g);
    btn_enter = 1'b1;
    repeat (20) @(negedge clk_g);
    btn_enter = 1'b0;
    repeat (15) @(negedge clk_g);
    check("bounce_one_done", 64'(n_done - d0), 64'd1);
    check("bounce_result", 64'(cal_result), 64'd7);

    // add / carry
    do_op(3'd0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0, 3, "load_big");
    do_op(3'd1, 32'h0000_000F, 32'hFFFF_FFFF, 1'b0, 3, "add_ok");
    do_op(3'd1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 3, "add_carry");

    // sub / borrow, reserved op
    do_op(3'd0, 32'd10, 32'd10, 1'b0, 3, "load_10");
    do_op(3'd2, 32'd3, 32'd7, 1'b0, 3, "sub_ok");
    do_op(3'd2, 32'd8, 32'd7, 1'b1, 3, "sub_borrow");
    do_op(3'd0, 32'd1, 32'd1, 1'b0, 3, "load_1");
    do_op(3'd6, 32'd2, 32'd1, 1'b1, 3, "reserved");

    // error is sticky: ADD ignored, LOAD clears
    d0 = n_done;
    busy_seen = 1'b0;
    @(negedge clk_g);
    op_sel = 3'd1;
    operand = 32'd5;
    btn_enter = 1'b1;
    repeat (15) @(negedge clk_g);
    btn_enter = 1'b0;
    repeat (15) @(negedge clk_g);
    check("err_ignore_done", 64'(n_done - d0), 64'd0);
    check("err_ignore_busy", 64'(busy_seen), 64'd0);
    check("err_ignore_state", {31'd0, error, cal_result}, {31'd0, 1'b1, 32'd1});
    do_op(3'd0, 32'd5, 32'd5, 1'b0, 3, "load_clears_err");

    // iterative ops
    do_op(3'd0, 32'd12345, 32'd12345, 1'b0, 3, "load_12345");
    do_op(3'd3, 32'd1000, 32'd12345000, 1'b0, 35, "mul");
    do_op(3'd0, 32'd100, 32'd100, 1'b0, 3, "load_100");
    do_op(3'd4, 32'd7, 32'd14, 1'b0, 35, "div");
    do_op(3'd0, 32'd100, 32'd100, 1'b0, 3, "load_100b");
    do_op(3'd5, 32'd7, 32'd2, 1'b0, 35, "mod");
    do_op(3'd4, 32'd0, 32'd2, 1'b1, 3, "div_zero");
    do_op(3'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, 3, "load_64k");
    do_op(3'd3, 32'h0001_0000, 32'h0001_0000, 1'b1, 35, "mul_ovf");

    // random operands against a reference computed here
    for (int k = 0; k < 3; k++) begin
      a = $urandom;
      b = $urandom_range(1, 1000);
      do_op(3'd0, a, a, 1'b0, 3, "rnd_load");
      do_op(3'd4, b, a / b, 1'b0, 35, "rnd_div");
      do_op(3'd0, a, a, 1'b0, 3, "rnd_load2");
      do_op(3'd5, b, a % b, 1'b0, 35, "rnd_mod");
      a = $urandom_range(0, 200000);
      b = $urandom_range(0, 30000);
      p = 64'(a) * 64'(b);
      do_op(3'd0, a, a, 1'b0, 3, "rnd_load3");
      do_op(3'd3, b, (p[63:32] != 0) ? a : p[31:0], p[63:32] != 0, 35, "rnd_mul");
    end

    // second go while busy is dropped
    do_op(3'd0, 32'd3, 32'd3, 1'b0, 3, "load_3");
    d0 = n_done;
    exp_q.push_back({1'b0, 32'd9});
    op_sel = 3'd3;
    operand = 32'd3;
    btn_enter = 1'b1;
    repeat (8) @(negedge clk_g);
    btn_enter = 1'b0;
    repeat (8) @(negedge clk_g);
    op_sel = 3'd1;
    operand = 32'd100;
    btn_enter = 1'b1;
    repeat (8) @(negedge clk_g);
    btn_enter = 1'b0;
    repeat (60) @(negedge clk_g);
    check("busy_go_one_done", 64'(n_done - d0), 64'd1);
    check("busy_go_result", 64'(cal_result), 64'd9);

    // clear during ITER aborts without done
    do_op(3'd0, 32'd12345, 32'd12345, 1'b0, 3, "load_pre_clr");
    d0 = n_done;
    op_sel = 3'd3;
    operand = 32'd1000;
    btn_enter = 1'b1;
    wait_iter("clr_reach_iter");
    repeat (3) @(negedge clk_g);
    btn_enter = 1'b0;
    btn_clear = 1'b1;
    repeat (10) @(negedge clk_g);
    btn_clear = 1'b0;
    repeat (50) @(negedge clk_g);
    check("clr_no_done", 64'(n_done - d0), 64'd0);
    check("clr_result", 64'(cal_result), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_state", 64'(dbg_state), 64'd0);

    // asynchronous reset in ITER
    do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, "load_pre_rst");
    op_sel = 3'd3;
    operand = 32'd2;
    btn_enter = 1'b1;
    wait_iter("rst_reach_iter");
    repeat (5) @(negedge clk_g);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", 64'(cal_result), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_error", 64'(error), 64'd0);
    check("arst_state", 64'(dbg_state), 64'd0);
    btn_enter = 1'b0;
    repeat (3) @(negedge clk_g);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_g);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
